// File: rtl/is_array_sequencer.sv
// Job sequencer for an input-stationary systolic array: loads one stationary input
// tile, streams num_vec weight vectors, drains with zero weights and tags each psum.
module is_array_sequencer #(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  parameter int OUT_LATENCY  = 8,
  parameter int CNT_W        = 8,
  localparam int AW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             psum_ready,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    input_rd_addr,
  output logic             input_en,
  output logic [CNT_W-1:0] weight_rd_addr,
  output logic             weight_zero,
  output logic             process_en,
  output logic             psum_valid,
  output logic [CNT_W-1:0] psum_addr,
  output logic [2:0]       state_dbg
);

  localparam int DW = $clog2(OUT_LATENCY + 1);
  localparam logic [AW-1:0] LOAD_FIRST = AW'(ARRAY_WIDTH - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(OUT_LATENCY - 1);

  if (OUT_LATENCY < 1 || ARRAY_HEIGHT < 1 || ARRAY_WIDTH < 1) begin : g_param_check
    $error("is_array_sequencer: OUT_LATENCY, ARRAY_HEIGHT and ARRAY_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       num_vec_q, num_vec_d;
  logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
  logic [OUT_LATENCY-1:0] vld_q, vld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   input_en_q, input_en_d;
  logic [AW-1:0]          input_rd_addr_q, input_rd_addr_d;
  logic [CNT_W-1:0]       weight_rd_addr_q, weight_rd_addr_d;
  logic                   weight_zero_q, weight_zero_d;
  logic                   active_q, active_d;
  logic [CNT_W-1:0]       psum_addr_q, psum_addr_d;
  logic                   issue;

  // psum_ready gates the whole array pipeline in the same cycle, so the enable is not registered.
  assign process_en     = active_q & psum_ready;
  assign issue          = process_en & (state_q == S_STREAM);
  assign psum_valid     = vld_q[OUT_LATENCY-1] & psum_ready;
  assign busy           = busy_q;
  assign done           = done_q;
  assign input_en       = input_en_q;
  assign input_rd_addr  = input_rd_addr_q;
  assign weight_rd_addr = weight_rd_addr_q;
  assign weight_zero    = weight_zero_q;
  assign psum_addr      = psum_addr_q;
  assign state_dbg      = state_q;

  always_comb begin
    state_d          = state_q;
    num_vec_d        = num_vec_q;
    drain_cnt_d      = drain_cnt_q;
    vld_d            = vld_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    input_en_d       = input_en_q;
    input_rd_addr_d  = input_rd_addr_q;
    weight_rd_addr_d = weight_rd_addr_q;
    weight_zero_d    = weight_zero_q;
    active_d         = active_q;
    psum_addr_d      = psum_valid ? psum_addr_q + CNT_W'(1) : psum_addr_q;

    if (process_en) begin
      for (int i = OUT_LATENCY - 1; i > 0; i--) vld_d[i] = vld_q[i-1];
      vld_d[0] = issue;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d          = S_LOAD;
          num_vec_d        = num_vec;
          busy_d           = 1'b1;
          input_en_d       = 1'b1;
          input_rd_addr_d  = LOAD_FIRST;
          weight_rd_addr_d = '0;
          psum_addr_d      = '0;
          drain_cnt_d      = '0;
        end
      end
      S_LOAD: begin
        if (input_rd_addr_q == '0) begin
          input_en_d = 1'b0;
          if (num_vec_q != '0) begin
            state_d  = S_STREAM;
            active_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          input_rd_addr_d = input_rd_addr_q - AW'(1);
        end
      end
      S_STREAM: begin
        if (process_en) begin
          if (weight_rd_addr_q == num_vec_q - CNT_W'(1)) begin
            state_d       = S_DRAIN;
            weight_zero_d = 1'b1;
          end else begin
            weight_rd_addr_d = weight_rd_addr_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // The last psum leaves on the OUT_LATENCY-th enabled cycle after the final issue.
        if (process_en) begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d       = S_DONE;
            active_d      = 1'b0;
            weight_zero_d = 1'b0;
            done_d        = 1'b1;
            busy_d        = 1'b0;
          end else begin
            drain_cnt_d = drain_cnt_q + DW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      num_vec_q        <= '0;
      drain_cnt_q      <= '0;
      vld_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      input_en_q       <= 1'b0;
      input_rd_addr_q  <= '0;
      weight_rd_addr_q <= '0;
      weight_zero_q    <= 1'b0;
      active_q         <= 1'b0;
      psum_addr_q      <= '0;
    end else begin
      state_q          <= state_d;
      num_vec_q        <= num_vec_d;
      drain_cnt_q      <= drain_cnt_d;
      vld_q            <= vld_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      input_en_q       <= input_en_d;
      input_rd_addr_q  <= input_rd_addr_d;
      weight_rd_addr_q <= weight_rd_addr_d;
      weight_zero_q    <= weight_zero_d;
      active_q         <= active_d;
      psum_addr_q      <= psum_addr_d;
    end
  end

endmodule

// File: tb/tb_is_array_sequencer.sv
// Directed bench for is_array_sequencer: per-cycle output signatures compared against
// hand-derived job timelines (W=H=4, OUT_LATENCY=8, CNT_W=8).
module tb_is_array_sequencer;

  localparam int CW = 8;
  localparam int NCYC = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic          psum_ready = 1'b1;
  logic          busy, done, input_en, weight_zero, process_en, psum_valid;
  logic [1:0]    input_rd_addr;
  logic [CW-1:0] weight_rd_addr, psum_addr;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  logic [15:0]   got   [0:NCYC-1];
  logic [CW-1:0] wa    [0:NCYC-1];
  logic          st_tab[0:NCYC-1];
  logic          rd_tab[0:NCYC-1];
  logic [CW-1:0] nv_tab[0:NCYC-1];
  logic [CW-1:0] exp_q[$];

  is_array_sequencer #(
    .ARRAY_HEIGHT(4), .ARRAY_WIDTH(4), .OUT_LATENCY(8), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .psum_ready(psum_ready),
    .busy(busy), .done(done), .input_rd_addr(input_rd_addr), .input_en(input_en),
    .weight_rd_addr(weight_rd_addr), .weight_zero(weight_zero), .process_en(process_en),
    .psum_valid(psum_valid), .psum_addr(psum_addr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sig(input logic by, input logic dn, input logic ie,
                                      input logic [1:0] ir, input logic pe, input logic wz,
                                      input logic pv, input logic [7:0] pa);
    return {by, dn, ie, ir, pe, wz, pv, pa};
  endfunction

  task automatic clear_tabs();
    for (int i = 0; i < NCYC; i++) begin
      st_tab[i] = 1'b0;
      rd_tab[i] = 1'b1;
      nv_tab[i] = '0;
    end
  endtask

  // Entered at a negedge; cycle c inputs are applied and outputs sampled 1ns later.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      start      = st_tab[c];
      psum_ready = rd_tab[c];
      num_vec    = nv_tab[c];
      #1;
      got[c] = {busy, done, input_en, input_rd_addr, process_en, weight_zero, psum_valid, psum_addr};
      wa[c]  = weight_rd_addr;
      @(negedge clk);
    end
    start      = 1'b0;
    psum_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] g;
    @(negedge clk);
    #1;
    g = {busy, done, input_en, input_rd_addr, process_en, weight_zero, psum_valid, psum_addr};
    checks++;
    if (g !== 16'h0) begin errors++; $display("FAIL reset_outputs got %h exp 0000", g); end
    checks++;
    if (weight_rd_addr !== 8'h0) begin errors++; $display("FAIL reset_waddr got %h exp 00", weight_rd_addr); end
    checks++;
    if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    g = {busy, done, input_en, input_rd_addr, process_en, weight_zero, psum_valid, psum_addr};
    checks++;
    if (g !== 16'h0) begin errors++; $display("FAIL idle_outputs got %h exp 0000", g); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    logic [15:0] g;
    clear_tabs();
    st_tab[0] = 1'b1;
    nv_tab[0] = 8'd6;
    run_cycles(8);
    #1;
    checks++;
    if (weight_rd_addr !== 8'd3 || process_en !== 1'b1) begin
      errors++; $display("FAIL midrst_issue3 got waddr %0d pe %b exp waddr 3 pe 1", weight_rd_addr, process_en);
    end
    rst_n = 1'b0;
    #1;
    g = {busy, done, input_en, input_rd_addr, process_en, weight_zero, psum_valid, psum_addr};
    checks++;
    if (g !== 16'h0 || weight_rd_addr !== 8'h0 || state_dbg !== 3'd0) begin
      errors++; $display("FAIL midrst_zero got sig %h waddr %h st %0d exp 0000 00 0", g, weight_rd_addr, state_dbg);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_tabs();
    run_cycles(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (got[c] !== 16'h0) begin errors++; $display("FAIL midrst_quiet c=%0d got %h exp 0000", c, got[c]); end
    end
  endtask

  task automatic test_basic();
    logic ie, pe, wz, pv, by, dn;
    logic [1:0] ir;
    logic [7:0] pa;
    clear_tabs();
    st_tab[0] = 1'b1;
    nv_tab[0] = 8'd3;
    run_cycles(20);
    for (int c = 1; c < 20; c++) begin
      ie = (c >= 1 && c <= 4);
      ir = ie ? 2'(4 - c) : 2'd0;
      pe = (c >= 5 && c <= 15);
      wz = (c >= 8 && c <= 15);
      pv = (c >= 13 && c <= 15);
      pa = (c < 13) ? 8'd0 : (pv ? 8'(c - 13) : 8'd3);
      by = (c >= 1 && c <= 15);
      dn = (c == 16);
      checks++;
      if (got[c] !== sig(by, dn, ie, ir, pe, wz, pv, pa)) begin
        errors++; $display("FAIL basic c=%0d got %h exp %h", c, got[c], sig(by, dn, ie, ir, pe, wz, pv, pa));
      end
    end
    for (int c = 5; c < 8; c++) begin
      checks++;
      if (wa[c] !== 8'(c - 5)) begin errors++; $display("FAIL basic_waddr c=%0d got %0d exp %0d", c, wa[c], c - 5); end
    end
  endtask

  task automatic test_stall();
    logic ie, pe, wz, pv, by, dn;
    logic [1:0] ir;
    logic [7:0] pa;
    logic [7:0] wexp [0:4];
    wexp[0] = 8'd0; wexp[1] = 8'd1; wexp[2] = 8'd1; wexp[3] = 8'd1; wexp[4] = 8'd2;
    clear_tabs();
    st_tab[0] = 1'b1;
    nv_tab[0] = 8'd3;
    rd_tab[6] = 1'b0; rd_tab[7] = 1'b0;
    rd_tab[16] = 1'b0; rd_tab[17] = 1'b0; rd_tab[18] = 1'b0;
    run_cycles(24);
    exp_q = {8'd0, 8'd1, 8'd2};
    for (int c = 1; c < 24; c++) begin
      ie = (c >= 1 && c <= 4);
      ir = ie ? 2'(4 - c) : 2'd0;
      pe = (c >= 5 && c <= 20) && rd_tab[c];
      wz = (c >= 10 && c <= 20);
      pv = (c == 15 || c == 19 || c == 20);
      pa = (c <= 15) ? 8'd0 : (c <= 19) ? 8'd1 : (c == 20) ? 8'd2 : 8'd3;
      by = (c >= 1 && c <= 20);
      dn = (c == 21);
      checks++;
      if (got[c] !== sig(by, dn, ie, ir, pe, wz, pv, pa)) begin
        errors++; $display("FAIL stall c=%0d got %h exp %h", c, got[c], sig(by, dn, ie, ir, pe, wz, pv, pa));
      end
      if (got[c][8]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra_psum c=%0d got addr %0d exp none", c, got[c][7:0]);
        end else if (got[c][7:0] !== exp_q[0]) begin
          errors++; $display("FAIL stall_psum_addr c=%0d got %0d exp %0d", c, got[c][7:0], exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_missing_psums got %0d left exp 0", exp_q.size()); end
    for (int c = 5; c < 10; c++) begin
      checks++;
      if (wa[c] !== wexp[c-5]) begin errors++; $display("FAIL stall_waddr c=%0d got %0d exp %0d", c, wa[c], wexp[c-5]); end
    end
  endtask

  task automatic test_zero_vec();
    logic ie, by, dn;
    logic [1:0] ir;
    clear_tabs();
    st_tab[0] = 1'b1;
    nv_tab[0] = 8'd0;
    run_cycles(8);
    for (int c = 1; c < 8; c++) begin
      ie = (c >= 1 && c <= 4);
      ir = ie ? 2'(4 - c) : 2'd0;
      by = ie;
      dn = (c == 5);
      checks++;
      if (got[c] !== sig(by, dn, ie, ir, 1'b0, 1'b0, 1'b0, 8'd0)) begin
        errors++; $display("FAIL zero_vec c=%0d got %h exp %h", c, got[c], sig(by, dn, ie, ir, 1'b0, 1'b0, 1'b0, 8'd0));
      end
    end
  endtask

  task automatic test_start_held();
    logic ie, pe, wz, pv, by, dn;
    logic [1:0] ir;
    logic [7:0] pa;
    clear_tabs();
    for (int i = 0; i < 19; i++) begin
      st_tab[i] = 1'b1;
      nv_tab[i] = 8'd2;
    end
    run_cycles(19);
    for (int c = 1; c < 19; c++) begin
      ie = (c >= 1 && c <= 4) || (c >= 17);
      ir = (c >= 17) ? 2'(20 - c) : (ie ? 2'(4 - c) : 2'd0);
      pe = (c >= 5 && c <= 14);
      wz = (c >= 7 && c <= 14);
      pv = (c == 13 || c == 14);
      pa = (c == 14) ? 8'd1 : (c == 15 || c == 16) ? 8'd2 : 8'd0;
      by = (c >= 1 && c <= 14) || (c >= 17);
      dn = (c == 15);
      checks++;
      if (got[c] !== sig(by, dn, ie, ir, pe, wz, pv, pa)) begin
        errors++; $display("FAIL start_held c=%0d got %h exp %h", c, got[c], sig(by, dn, ie, ir, pe, wz, pv, pa));
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Closed-form timeline of an unstalled job started at cycle s with count nv.
  task automatic test_back_to_back();
    int s, nv, t;
    logic ie, pe, wz, pv, by, dn;
    logic [1:0] ir;
    logic [7:0] pa;
    clear_tabs();
    st_tab[0] = 1'b1;
    nv_tab[0] = 8'd1;
    for (int i = 1; i < 15; i++) nv_tab[i] = 8'd9;
    st_tab[15] = 1'b1;
    nv_tab[15] = 8'd5;
    for (int i = 16; i < 34; i++) nv_tab[i] = 8'd9;
    run_cycles(34);
    for (int c = 1; c < 34; c++) begin
      s  = (c < 15) ? 0 : 15;
      nv = (c < 15) ? 1 : 5;
      t  = c - s;
      ie = (t >= 1 && t <= 4);
      ir = ie ? 2'(4 - t) : 2'd0;
      pe = (t >= 5 && t <= 12 + nv);
      wz = (t >= 5 + nv && t <= 12 + nv);
      pv = (t >= 13 && t <= 12 + nv);
      pa = (t == 0) ? 8'd1 : (t < 13) ? 8'd0 : (pv ? 8'(t - 13) : 8'(nv));
      by = (t >= 1 && t <= 12 + nv);
      dn = (t == 13 + nv);
      checks++;
      if (got[c] !== sig(by, dn, ie, ir, pe, wz, pv, pa)) begin
        errors++; $display("FAIL back_to_back c=%0d got %h exp %h", c, got[c], sig(by, dn, ie, ir, pe, wz, pv, pa));
      end
    end
  endtask

  task automatic test_max_count();
    int nv, pv_cnt;
    logic [7:0] last_pa;
    nv = 255;
    pv_cnt = 0;
    last_pa = '0;
    clear_tabs();
    st_tab[0] = 1'b1;
    nv_tab[0] = 8'd255;
    run_cycles(270);
    for (int c = 1; c < 270; c++) begin
      if (got[c][8]) begin
        pv_cnt++;
        last_pa = got[c][7:0];
      end
    end
    checks++;
    if (pv_cnt != nv) begin errors++; $display("FAIL max_psum_count got %0d exp %0d", pv_cnt, nv); end
    checks++;
    if (last_pa !== 8'd254) begin errors++; $display("FAIL max_last_addr got %0d exp 254", last_pa); end
    checks++;
    if (got[268][14] !== 1'b1 || got[267][14] !== 1'b0) begin
      errors++; $display("FAIL max_done got c267=%b c268=%b exp 0 1", got[267][14], got[268][14]);
    end
    checks++;
    if (wa[259] !== 8'd254 || got[260][9] !== 1'b1) begin
      errors++; $display("FAIL max_last_issue got waddr %0d wz %b exp 254 1", wa[259], got[260][9]);
    end
  endtask

  initial begin
    clear_tabs();
    test_reset();
    test_reset_mid_stream();
    test_basic();
    test_stall();
    test_zero_vec();
    test_start_held();
    test_back_to_back();
    test_max_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
